pixel2superpixel_tracker: RTL and testbench
===========================================

// Module: pixel2superpixel_tracker
// PURPOSE
//  Inverse of superpixel-to-pixel mapping: follows the VGA raster (pix_x, pix_y)
//  and yields the owning superpixel (spx_x, spx_y), intra-cell offset and a
//  superpixel buffer address, one registered cycle later. Division-free, using
//  incremental cell/sub-cell counters resynced at line/frame start.
//  Sits between the VGA timing generator and the superpixel frame-buffer read port.
// PARAMETERS
//  SPIXEL_X_WIDTH  6    superpixel column index width
//  SPIXEL_Y_WIDTH  6    superpixel row index width
//  SPIXEL_X_MAX    63   last superpixel column
//  SPIXEL_Y_MAX    47   last superpixel row
//  PIXEL_X_WIDTH   10   pixel column width
//  PIXEL_Y_WIDTH   9    pixel row width
//  PIXEL_X_MAX     639  last visible pixel column
//  PIXEL_Y_MAX     479  last visible pixel row
//  (local) SPIXEL_PHY = (PIXEL_X_MAX+1)/(SPIXEL_X_MAX+1) = 10 pixels per cell edge
// PORTS
//  clk        in   1                 system clock; sole clock
//  rst        in   1                 synchronous, active-high reset
//  pix_valid  in   1                 pix_x/pix_y is a visible pixel this cycle
//  pix_x      in   PIXEL_X_WIDTH     raster column
//  pix_y      in   PIXEL_Y_WIDTH     raster row
//  spx_valid  out  1                 outputs below describe the pixel sampled last cycle
//  spx_x      out  SPIXEL_X_WIDTH    superpixel column
//  spx_y      out  SPIXEL_Y_WIDTH    superpixel row
//  sub_x      out  4                 column offset in cell, 0..SPIXEL_PHY-1
//  sub_y      out  4                 row offset in cell, 0..SPIXEL_PHY-1
//  spx_addr   out  SPIXEL_X_WIDTH+SPIXEL_Y_WIDTH  {spx_y, spx_x}
//  spx_border out  1                 pixel lies on cell edge (see CONFIGURATION)
//  sync_err   out  1                 1-cycle pulse: raster discontinuity detected
// BEHAVIOUR
//  - Reset: all outputs 0; internal counters 0; state UNSYNCED.
//  - Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
//  - States: UNSYNCED, TRACK. UNSYNCED->TRACK on valid pixel with pix_x==0 and
//    pix_y==0. TRACK->UNSYNCED on any discontinuity (sync_err=1 that cycle).
//  - X tracking (TRACK, pix_valid=1): pix_x==0 -> sub_x=0, spx_x=0;
//    pix_x==last_x+1 -> sub_x+1, wrap SPIXEL_PHY-1->0 with spx_x+1;
//    any other pix_x -> discontinuity.
//  - Y tracking at each pix_x==0: pix_y==0 -> sub_y=0, spx_y=0;
//    pix_y==last_y+1 -> sub_y+1, wrap to 0 with spx_y+1; pix_y==last_y -> hold;
//    else discontinuity.
//  - pix_x>PIXEL_X_MAX or pix_y>PIXEL_Y_MAX with pix_valid: discontinuity.
//  - spx_valid=1 only for valid pixels processed in TRACK; pix_valid=0 -> spx_valid=0,
//    counters and last_x/last_y hold (blanking is not a discontinuity).
//  - Invalid cycles hold spx_x/spx_y/sub_x/sub_y/spx_addr at last value.
//  - Counters never exceed SPIXEL_X_MAX / SPIXEL_Y_MAX; legal raster guarantees it.
//  - Invariant in TRACK: spx_x*SPIXEL_PHY+sub_x == pix_x (same for y).
//  - rst mid-frame: immediate return to reset values; resync at next (0,0).
// CONFIGURATION
//  SPIXEL_BORDER_EN defined: spx_border=1 (registered, same latency) when spx_valid
//   and sub_x or sub_y equals 0 or SPIXEL_PHY-1; else 0.
//  SPIXEL_BORDER_EN undefined: spx_border tied 0, no border logic synthesised.
// TESTING
//  1 rst then pixels (0,0),(1,0) -> after 1 cycle spx=(0,0) sub=(0,0), then sub_x=1, valid=1.
//  2 pix (9,0)->(10,0) -> spx_x 0->1, sub_x 9->0; (639,0) -> spx_x=63, sub_x=9, addr=63.
//  3 row 19->20 at pix_x=0 -> spx_y=2, sub_y=0; (639,479) -> spx=(63,47), addr=0xBFF.
//  4 in TRACK jump (5,3)->(8,3) -> sync_err pulse, spx_valid=0 until next (0,0).
//  5 pixels before first (0,0), e.g. (100,50) -> spx_valid=0, sync_err=0.
//  6 SPIXEL_BORDER_EN: (10,0)->border=1, (15,5)->0; undefined: border always 0.

Source files
------------

// File: rtl/pixel2superpixel_tracker.sv
// pixel2superpixel_tracker
// Follows the VGA raster (pix_x, pix_y) and reports the owning superpixel
// cell, the offset inside that cell and the superpixel buffer address. All
// outputs are registered and appear one cycle after the pixel is sampled.
// No division is used. Cell and sub-cell counters step with the raster and
// resync at line start (pix_x == 0) and frame start (0,0).
// Optional feature: define SPIXEL_BORDER_EN to register a cell-edge flag on
// spx_border. Without it, spx_border is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// UNSYNCED | waiting for pixel (0,0); spx_valid stays low
// TRACK    | counters follow the raster; any break returns to UNSYNCED
module pixel2superpixel_tracker #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int SPIXEL_X_MAX   = 63,
    parameter int SPIXEL_Y_MAX   = 47,
    parameter int PIXEL_X_WIDTH  = 10,
    parameter int PIXEL_Y_WIDTH  = 9,
    parameter int PIXEL_X_MAX    = 639,
    parameter int PIXEL_Y_MAX    = 479
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_valid,
    input  logic [PIXEL_X_WIDTH-1:0]               pix_x,
    input  logic [PIXEL_Y_WIDTH-1:0]               pix_y,
    output logic                                   spx_valid,
    output logic [SPIXEL_X_WIDTH-1:0]              spx_x,
    output logic [SPIXEL_Y_WIDTH-1:0]              spx_y,
    output logic [3:0]                             sub_x,
    output logic [3:0]                             sub_y,
    output logic [SPIXEL_X_WIDTH+SPIXEL_Y_WIDTH-1:0] spx_addr,
    output logic                                   spx_border,
    output logic                                   sync_err
);

    localparam int SPIXEL_PHY = (PIXEL_X_MAX + 1) / (SPIXEL_X_MAX + 1);
    localparam logic [3:0] SUB_LAST = 4'(SPIXEL_PHY - 1);
    localparam logic [PIXEL_X_WIDTH-1:0] X_LAST = PIXEL_X_WIDTH'(PIXEL_X_MAX);
    localparam logic [PIXEL_Y_WIDTH-1:0] Y_LAST = PIXEL_Y_WIDTH'(PIXEL_Y_MAX);

    typedef enum logic {UNSYNCED, TRACK} state_t;

    state_t state, state_nxt;

    logic [PIXEL_X_WIDTH-1:0]  last_x, last_x_nxt;
    logic [PIXEL_Y_WIDTH-1:0]  last_y, last_y_nxt;
    logic [SPIXEL_X_WIDTH-1:0] spx_x_nxt;
    logic [SPIXEL_Y_WIDTH-1:0] spx_y_nxt;
    logic [3:0]                sub_x_nxt, sub_y_nxt;
    logic                      spx_valid_nxt, sync_err_nxt, accept;
    logic                      in_range, x_first, x_step, y_first, y_step, y_same;

    assign in_range = (pix_x <= X_LAST) && (pix_y <= Y_LAST);
    assign x_first  = (pix_x == '0);
    assign x_step   = (pix_x == last_x + 1'b1);
    assign y_first  = (pix_y == '0);
    assign y_step   = (pix_y == last_y + 1'b1);
    assign y_same   = (pix_y == last_y);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= UNSYNCED;
        else     state <= state_nxt;
    end

    // Next state, pixel acceptance and next counter values
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        sync_err_nxt  = 1'b0;
        spx_x_nxt     = spx_x;
        spx_y_nxt     = spx_y;
        sub_x_nxt     = sub_x;
        sub_y_nxt     = sub_y;
        last_x_nxt    = last_x;
        last_y_nxt    = last_y;

        if (pix_valid) begin
            case (state)
                UNSYNCED: begin
                    if (x_first && y_first) begin
                        accept    = 1'b1;
                        state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    // A row change in mid-line would break the row invariant,
                    // so a stepping column also requires an unchanged row.
                    if (in_range && x_first && (y_first || y_step || y_same))
                        accept = 1'b1;
                    else if (in_range && x_step && y_same)
                        accept = 1'b1;
                    else begin
                        sync_err_nxt = 1'b1;
                        state_nxt    = UNSYNCED;
                    end
                end
                default: state_nxt = UNSYNCED;
            endcase
        end

        if (accept) begin
            last_x_nxt = pix_x;
            last_y_nxt = pix_y;
            if (x_first) begin
                spx_x_nxt = '0;
                sub_x_nxt = '0;
                if (y_first) begin
                    spx_y_nxt = '0;
                    sub_y_nxt = '0;
                end else if (y_step) begin
                    if (sub_y == SUB_LAST) begin
                        sub_y_nxt = '0;
                        spx_y_nxt = spx_y + 1'b1;
                    end else begin
                        sub_y_nxt = sub_y + 1'b1;
                    end
                end
            end else if (sub_x == SUB_LAST) begin
                sub_x_nxt = '0;
                spx_x_nxt = spx_x + 1'b1;
            end else begin
                sub_x_nxt = sub_x + 1'b1;
            end
        end

        spx_valid_nxt = accept;
    end

    // Output and tracking registers; values hold through blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            spx_valid <= 1'b0;
            sync_err  <= 1'b0;
            spx_x     <= '0;
            spx_y     <= '0;
            sub_x     <= '0;
            sub_y     <= '0;
            last_x    <= '0;
            last_y    <= '0;
        end else begin
            spx_valid <= spx_valid_nxt;
            sync_err  <= sync_err_nxt;
            spx_x     <= spx_x_nxt;
            spx_y     <= spx_y_nxt;
            sub_x     <= sub_x_nxt;
            sub_y     <= sub_y_nxt;
            last_x    <= last_x_nxt;
            last_y    <= last_y_nxt;
        end
    end

    assign spx_addr = {spx_y, spx_x};

`ifdef SPIXEL_BORDER_EN
    logic border_nxt;

    assign border_nxt = accept &&
                        ((sub_x_nxt == '0) || (sub_x_nxt == SUB_LAST) ||
                         (sub_y_nxt == '0) || (sub_y_nxt == SUB_LAST));

    // Cell-edge flag, aligned with the other outputs
    always_ff @(posedge clk) begin
        if (rst) spx_border <= 1'b0;
        else     spx_border <= border_nxt;
    end
`else
    assign spx_border = 1'b0;
`endif

endmodule

// File: tb/tb_pixel2superpixel_tracker.sv
// Directed bench for pixel2superpixel_tracker with hand-computed expectations.
module tb_pixel2superpixel_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        spx_valid;
    logic [5:0]  spx_x, spx_y;
    logic [3:0]  sub_x, sub_y;
    logic [11:0] spx_addr;
    logic        spx_border, sync_err;

    int total = 0;
    int bad   = 0;

`ifdef SPIXEL_BORDER_EN
    localparam logic BORDER_ON = 1'b1;
`else
    localparam logic BORDER_ON = 1'b0;
`endif

    pixel2superpixel_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .spx_valid  (spx_valid),
        .spx_x      (spx_x),
        .spx_y      (spx_y),
        .sub_x      (sub_x),
        .sub_y      (sub_y),
        .spx_addr   (spx_addr),
        .spx_border (spx_border),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one input cycle; outputs are settled 1 ns after the edge.
    task automatic drive(input logic v, input int x, input int y);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic run_x(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) drive(1'b1, x, y);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 0);
        drive(1'b0, 0, 0);
        chk("rst_valid", spx_valid, 0);
        chk("rst_spx_x", spx_x, 0);
        chk("rst_spx_y", spx_y, 0);
        chk("rst_sub_x", sub_x, 0);
        chk("rst_addr", spx_addr, 0);
        chk("rst_err", sync_err, 0);
        chk("rst_border", spx_border, 0);
        rst = 1'b0;

        // pixels before the first (0,0) are ignored quietly
        drive(1'b1, 100, 50);
        chk("pre_valid", spx_valid, 0);
        chk("pre_err", sync_err, 0);

        // frame start
        drive(1'b1, 0, 0);
        chk("t1_valid", spx_valid, 1);
        chk("t1_spx", {spx_y, spx_x}, 0);
        chk("t1_sub", {sub_y, sub_x}, 0);
        chk("t1_border_00", spx_border, BORDER_ON);
        drive(1'b1, 1, 0);
        chk("t1_sub_x1", sub_x, 1);
        chk("t1_valid1", spx_valid, 1);

        // cell boundary in x
        run_x(0, 2, 9);
        chk("t2_sub_x9", sub_x, 9);
        chk("t2_spx_x0", spx_x, 0);
        drive(1'b1, 10, 0);
        chk("t2_spx_x1", spx_x, 1);
        chk("t2_sub_x0", sub_x, 0);
        chk("t2_border_10", spx_border, BORDER_ON);
        run_x(0, 11, 639);
        chk("t2_spx_x63", spx_x, 63);
        chk("t2_sub_x9e", sub_x, 9);
        chk("t2_addr63", spx_addr, 63);

        // blanking holds the outputs
        drive(1'b0, 0, 0);
        chk("blank_valid", spx_valid, 0);
        chk("blank_hold", spx_x, 63);
        chk("blank_err", sync_err, 0);

        // rows advance at line start
        for (int y = 1; y <= 19; y++) drive(1'b1, 0, y);
        chk("t3_sub_y9", sub_y, 9);
        chk("t3_spx_y1", spx_y, 1);
        drive(1'b1, 0, 20);
        chk("t3_spx_y2", spx_y, 2);
        chk("t3_sub_y0", sub_y, 0);
        for (int y = 21; y <= 479; y++) drive(1'b1, 0, y);
        run_x(479, 1, 639);
        chk("t3_spx_last", {spx_y, spx_x}, {6'd47, 6'd63});
        chk("t3_sub_last", {sub_y, sub_x}, {4'd9, 4'd9});
        chk("t3_addr_bff", spx_addr, 12'hBFF);

        // row repeated at line start holds y
        drive(1'b1, 0, 479);
        chk("hold_y_valid", spx_valid, 1);
        chk("hold_spx_y", spx_y, 47);
        chk("hold_spx_x", spx_x, 0);

        // column jump is a discontinuity
        drive(1'b1, 0, 0);
        for (int y = 1; y <= 3; y++) drive(1'b1, 0, y);
        run_x(3, 1, 5);
        chk("t4_pre_sub", {sub_y, sub_x}, {4'd3, 4'd5});
        drive(1'b1, 8, 3);
        chk("t4_err", sync_err, 1);
        chk("t4_valid", spx_valid, 0);
        drive(1'b1, 9, 3);
        chk("t4_err_pulse", sync_err, 0);
        chk("t4_still_invalid", spx_valid, 0);
        drive(1'b1, 0, 1);
        chk("t4_no_resync_y1", spx_valid, 0);
        drive(1'b1, 0, 0);
        chk("t4_resync", spx_valid, 1);

        // column past the visible edge is a discontinuity
        run_x(0, 1, 639);
        drive(1'b1, 640, 0);
        chk("range_err", sync_err, 1);
        chk("range_valid", spx_valid, 0);

        // interior pixel carries no border flag
        drive(1'b1, 0, 0);
        for (int y = 1; y <= 5; y++) drive(1'b1, 0, y);
        run_x(5, 1, 15);
        chk("t6_sub", {sub_y, sub_x}, {4'd5, 4'd5});
        chk("t6_spx_x", spx_x, 1);
        chk("t6_border_15_5", spx_border, 0);

        // reset in mid-frame
        rst = 1'b1;
        drive(1'b1, 16, 5);
        rst = 1'b0;
        chk("mid_rst_valid", spx_valid, 0);
        chk("mid_rst_spx", {spx_y, spx_x}, 0);
        chk("mid_rst_sub", {sub_y, sub_x}, 0);
        drive(1'b1, 17, 5);
        chk("mid_rst_unsync", spx_valid, 0);
        chk("mid_rst_noerr", sync_err, 0);
        drive(1'b1, 0, 0);
        chk("mid_rst_resync", spx_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
